// File: rtl/axi_lite_if.sv
// AXI-lite bus bundle: 32-bit address/data, 4-bit strobe, 2-bit response.
// master drives requests and ready for responses; slave is the mirror image.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_xbar_1x2.sv
// AXI-lite 1-to-2 crossbar: s0 = main memory, s1 = read-only CLINT, unmapped -> DECERR.
// Optional XBAR_DIFFTEST_SKIP_EN adds a difftest_skip pulse for device/error completions.
module axi_lite_xbar_1x2 #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_MASK   = 32'hF800_0000
) (
  input  logic             clk,
  input  logic             rst,
  axi_lite_if.slave        up,
  axi_lite_if.master       s0,
  axi_lite_if.master       s1,
  output logic [1:0]       r_state_dbg,
  output logic [1:0]       w_state_dbg
`ifdef XBAR_DIFFTEST_SKIP_EN
  ,
  output logic             difftest_skip
`endif
);
  // Handshakes: a transfer occurs on the rising edge where valid && ready;
  // valid never waits on ready, and payload is held stable while valid is high.
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_ERR} w_state_t;
  typedef enum logic [1:0] {T_MEM, T_CLINT, T_ERR} tgt_t;

  function automatic tgt_t decode(input logic [31:0] addr);
    if ((addr & CLINT_MASK) == CLINT_BASE) return T_CLINT;
    else if ((addr & MEM_MASK) == MEM_BASE) return T_MEM;
    else return T_ERR;
  endfunction

  r_state_t    r_state, r_next;
  logic [31:0] r_addr;
  tgt_t        r_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_tgt   <= T_MEM;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && up.arvalid) begin
        r_addr <= up.araddr;
        r_tgt  <= decode(up.araddr);
      end
    end
  end

  always_comb begin
    r_next     = r_state;
    up.arready = 1'b0;
    up.rvalid  = 1'b0;
    up.rdata   = '0;
    up.rresp   = '0;
    s0.arvalid = 1'b0;
    s1.arvalid = 1'b0;
    s0.rready  = 1'b0;
    s1.rready  = 1'b0;
    case (r_state)
      R_IDLE: begin
        up.arready = 1'b1;
        if (up.arvalid) r_next = (decode(up.araddr) == T_ERR) ? R_ERR : R_ADDR;
      end
      R_ADDR: begin
        if (r_tgt == T_CLINT) begin
          s1.arvalid = 1'b1;
          if (s1.arready) r_next = R_DATA;
        end else begin
          s0.arvalid = 1'b1;
          if (s0.arready) r_next = R_DATA;
        end
      end
      R_DATA: begin
        if (r_tgt == T_CLINT) begin
          up.rvalid = s1.rvalid;
          up.rdata  = s1.rdata;
          up.rresp  = s1.rresp;
          s1.rready = up.rready;
          if (s1.rvalid && up.rready) r_next = R_IDLE;
        end else begin
          up.rvalid = s0.rvalid;
          up.rdata  = s0.rdata;
          up.rresp  = s0.rresp;
          s0.rready = up.rready;
          if (s0.rvalid && up.rready) r_next = R_IDLE;
        end
      end
      R_ERR: begin
        up.rvalid = 1'b1;
        up.rresp  = 2'b11;
        if (up.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign s0.araddr = r_addr;
  assign s1.araddr = r_addr;

  w_state_t    w_state, w_next;
  logic        aw_got, w_got, aw_done, w_done;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  tgt_t        w_tgt, aw_tgt_now;
  logic        aw_fire, w_fire;

  // AW and W are captured independently; the target comes from the AW beat.
  assign aw_fire    = (w_state == W_IDLE) && !aw_got && up.awvalid;
  assign w_fire     = (w_state == W_IDLE) && !w_got && up.wvalid;
  assign aw_tgt_now = aw_fire ? decode(up.awaddr) : w_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_tgt   <= T_MEM;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_got  <= 1'b1;
        aw_addr <= up.awaddr;
        w_tgt   <= decode(up.awaddr);
      end
      if (w_fire) begin
        w_got  <= 1'b1;
        w_data <= up.wdata;
        w_strb <= up.wstrb;
      end
      if (w_state == W_ADDR) begin
        if (s0.awvalid && s0.awready) aw_done <= 1'b1;
        if (s0.wvalid && s0.wready) w_done <= 1'b1;
      end
      if (w_state != W_IDLE && w_next == W_IDLE) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = w_state;
    up.awready = 1'b0;
    up.wready  = 1'b0;
    up.bvalid  = 1'b0;
    up.bresp   = '0;
    s0.awvalid = 1'b0;
    s0.wvalid  = 1'b0;
    s0.bready  = 1'b0;
    case (w_state)
      W_IDLE: begin
        up.awready = !aw_got;
        up.wready  = !w_got;
        // The CLINT is read-only, so only memory writes are forwarded.
        if ((aw_got || aw_fire) && (w_got || w_fire))
          w_next = (aw_tgt_now == T_MEM) ? W_ADDR : W_ERR;
      end
      W_ADDR: begin
        s0.awvalid = !aw_done;
        s0.wvalid  = !w_done;
        if ((aw_done || s0.awready) && (w_done || s0.wready)) w_next = W_RESP;
      end
      W_RESP: begin
        up.bvalid = s0.bvalid;
        up.bresp  = s0.bresp;
        s0.bready = up.bready;
        if (s0.bvalid && up.bready) w_next = W_IDLE;
      end
      W_ERR: begin
        up.bvalid = 1'b1;
        up.bresp  = 2'b11;
        if (up.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign s0.awaddr = aw_addr;
  assign s0.wdata  = w_data;
  assign s0.wstrb  = w_strb;
  assign s1.awaddr  = '0;
  assign s1.awvalid = 1'b0;
  assign s1.wdata   = '0;
  assign s1.wstrb   = '0;
  assign s1.wvalid  = 1'b0;
  assign s1.bready  = 1'b0;

  logic unused_s1_wr;
  assign unused_s1_wr = ^{s1.awready, s1.wready, s1.bvalid, s1.bresp};

  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

`ifdef XBAR_DIFFTEST_SKIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) difftest_skip <= 1'b0;
    else difftest_skip <= (r_state == R_DATA && r_tgt == T_CLINT && s1.rvalid && up.rready)
                       || (r_state == R_ERR && up.rready)
                       || (w_state == W_ERR && up.bready);
  end
`endif
endmodule
